// File: rtl/memory_arbiter_if.sv
// Bus bundle between the cpu/aux requesters, the arbiter and the block RAM.
// The arbiter uses the slave modport; requesters and RAM sit on the master side.
interface memory_arbiter_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16
);
  // cpu requester
  logic                  cpu_request;
  logic                  cpu_write_enable;
  logic [ADDR_WIDTH-1:0] cpu_address;
  logic [DATA_WIDTH-1:0] cpu_write_data;
  logic                  cpu_grant;
  logic                  cpu_read_valid;
  logic [DATA_WIDTH-1:0] cpu_read_data;

  // auxiliary requester
  logic                  aux_request;
  logic                  aux_write_enable;
  logic [ADDR_WIDTH-1:0] aux_address;
  logic [DATA_WIDTH-1:0] aux_write_data;
  logic                  aux_grant;
  logic                  aux_read_valid;
  logic [DATA_WIDTH-1:0] aux_read_data;

  // block RAM port
  logic [DATA_WIDTH-1:0] memory_read_data;
  logic                  memory_write_enable;
  logic [ADDR_WIDTH-1:0] memory_address;
  logic [DATA_WIDTH-1:0] memory_write_data;

  modport slave (
    input  cpu_request, cpu_write_enable, cpu_address, cpu_write_data,
    output cpu_grant, cpu_read_valid, cpu_read_data,
    input  aux_request, aux_write_enable, aux_address, aux_write_data,
    output aux_grant, aux_read_valid, aux_read_data,
    input  memory_read_data,
    output memory_write_enable, memory_address, memory_write_data
  );

  modport master (
    output cpu_request, cpu_write_enable, cpu_address, cpu_write_data,
    input  cpu_grant, cpu_read_valid, cpu_read_data,
    output aux_request, aux_write_enable, aux_address, aux_write_data,
    input  aux_grant, aux_read_valid, aux_read_data,
    output memory_read_data,
    input  memory_write_enable, memory_address, memory_write_data
  );
endinterface

// File: rtl/memory_arbiter.sv
// Two-requester (cpu/aux) arbiter for a single-port block RAM.
// Same-cycle grant, round-robin on contention with a bounded hold window,
// and a tagged 1-cycle read return so data is flagged only to the reader.
module memory_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int MAX_HOLD   = 4
) (
  input  logic              clock,
  input  logic              reset,
  memory_arbiter_if.slave   bus
);

  localparam int RL_W = $clog2(MAX_HOLD + 1);
  localparam logic [RL_W-1:0] HOLD_LIMIT = RL_W'(MAX_HOLD);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_AUX  = 2'd2
  } owner_t;

  owner_t          r_owner;
  owner_t          r_last_owner;
  logic [RL_W-1:0] r_run_length;
  logic            r_pend_valid;
  logic            r_pend_aux;

  owner_t                w_winner;
  logic                  w_cpu_req;
  logic                  w_aux_req;
  logic                  w_cpu_hold_ok;
  logic                  w_aux_hold_ok;
  logic                  w_mem_we;
  logic [ADDR_WIDTH-1:0] w_mem_addr;
  logic [DATA_WIDTH-1:0] w_mem_wdata;

  // Requests are masked while reset is held so no grant or strobe can leak out.
  always_comb begin
    w_cpu_req = bus.cpu_request & reset;
    w_aux_req = bus.aux_request & reset;
  end

  // Current owner may keep the port while under its hold budget or while uncontended.
  always_comb begin
    w_cpu_hold_ok = (r_owner == OWN_CPU) && w_cpu_req &&
                    ((r_run_length < HOLD_LIMIT) || !w_aux_req);
    w_aux_hold_ok = (r_owner == OWN_AUX) && w_aux_req &&
                    ((r_run_length < HOLD_LIMIT) || !w_cpu_req);
  end

  // Winner selection in priority order: owner hold, sole requester, round-robin tie.
  always_comb begin
    w_winner = OWN_NONE;
    if (w_cpu_hold_ok) begin
      w_winner = OWN_CPU;
    end else if (w_aux_hold_ok) begin
      w_winner = OWN_AUX;
    end else if (w_cpu_req && !w_aux_req) begin
      w_winner = OWN_CPU;
    end else if (w_aux_req && !w_cpu_req) begin
      w_winner = OWN_AUX;
    end else if (w_cpu_req && w_aux_req) begin
      w_winner = (r_last_owner == OWN_CPU) ? OWN_AUX : OWN_CPU;
    end
  end

  // Steer the winner's operands onto the RAM port; all zero when idle.
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_addr  = '0;
    w_mem_wdata = '0;
    case (w_winner)
      OWN_CPU: begin
        w_mem_we    = bus.cpu_write_enable;
        w_mem_addr  = bus.cpu_address;
        w_mem_wdata = bus.cpu_write_data;
      end
      OWN_AUX: begin
        w_mem_we    = bus.aux_write_enable;
        w_mem_addr  = bus.aux_address;
        w_mem_wdata = bus.aux_write_data;
      end
      default: begin
        w_mem_we    = 1'b0;
        w_mem_addr  = '0;
        w_mem_wdata = '0;
      end
    endcase
  end

  // Arbitration state and read-return tag; reset drops any in-flight read.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_owner      <= OWN_NONE;
      r_last_owner <= OWN_AUX;
      r_run_length <= '0;
      r_pend_valid <= 1'b0;
      r_pend_aux   <= 1'b0;
    end else begin
      r_owner <= w_winner;
      if (w_winner != OWN_NONE) begin
        r_last_owner <= w_winner;
      end

      if (w_winner == OWN_NONE) begin
        r_run_length <= '0;
      end else if (w_winner != r_owner) begin
        r_run_length <= RL_W'(1);
      end else if (r_run_length < HOLD_LIMIT) begin
        r_run_length <= r_run_length + RL_W'(1);
      end

      r_pend_valid <= (w_winner != OWN_NONE) && !w_mem_we;
      r_pend_aux   <= (w_winner == OWN_AUX);
    end
  end

  assign bus.cpu_grant           = (w_winner == OWN_CPU);
  assign bus.aux_grant           = (w_winner == OWN_AUX);
  assign bus.memory_write_enable = w_mem_we;
  assign bus.memory_address      = w_mem_addr;
  assign bus.memory_write_data   = w_mem_wdata;

  // Read data fans out to both requesters; only the tagged read_valid qualifies it.
  assign bus.cpu_read_valid = r_pend_valid && !r_pend_aux;
  assign bus.aux_read_valid = r_pend_valid &&  r_pend_aux;
  assign bus.cpu_read_data  = bus.memory_read_data;
  assign bus.aux_read_data  = bus.memory_read_data;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter with a 1-cycle-latency RAM stand-in.
module tb_memory_arbiter;

  logic clock;
  logic reset;
  int unsigned total;
  int unsigned bad;

  memory_arbiter_if #(.DATA_WIDTH(16), .ADDR_WIDTH(16)) bus ();

  memory_arbiter #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .MAX_HOLD(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // RAM contents: address 0x0010 holds 0xBEEF, everything else addr ^ 0xA5A5.
  function automatic logic [15:0] ram_word(input logic [15:0] a);
    return (a == 16'h0010) ? 16'hBEEF : (a ^ 16'hA5A5);
  endfunction

  always @(posedge clock) bus.memory_read_data <= ram_word(bus.memory_address);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_cpu(input logic req, input logic we, input logic [15:0] a, input logic [15:0] d);
    bus.cpu_request = req; bus.cpu_write_enable = we; bus.cpu_address = a; bus.cpu_write_data = d;
  endtask

  task automatic drive_aux(input logic req, input logic we, input logic [15:0] a, input logic [15:0] d);
    bus.aux_request = req; bus.aux_write_enable = we; bus.aux_address = a; bus.aux_write_data = d;
  endtask

  logic        exp_cpu;
  logic        prev_cpu;
  logic [15:0] cur_addr;
  logic [15:0] prev_addr;
  int unsigned cpu_n;
  int unsigned aux_n;
  logic [6:0]  t5_cpu_req;
  logic [6:0]  t5_exp_cpu;

  initial begin
    total = 0;
    bad   = 0;
    bus.memory_read_data = '0;

    // 1: reset held, both requesting (cpu even tries a write)
    reset = 1'b0;
    drive_cpu(1'b1, 1'b1, 16'h0055, 16'h0077);
    drive_aux(1'b1, 1'b0, 16'h0066, 16'h0000);
    @(negedge clock);
    chk("rst_cpu_grant", bus.cpu_grant, 0);
    chk("rst_aux_grant", bus.aux_grant, 0);
    chk("rst_mem_we", bus.memory_write_enable, 0);
    chk("rst_cpu_rv", bus.cpu_read_valid, 0);
    chk("rst_aux_rv", bus.aux_read_valid, 0);
    tick();

    // 2: cpu-only read of 0x0010
    reset = 1'b1;
    drive_cpu(1'b1, 1'b0, 16'h0010, 16'h0000);
    drive_aux(1'b0, 1'b0, 16'h0000, 16'h0000);
    @(negedge clock);
    chk("rd_cpu_grant", bus.cpu_grant, 1);
    chk("rd_aux_grant", bus.aux_grant, 0);
    chk("rd_mem_addr", bus.memory_address, 16'h0010);
    chk("rd_mem_we", bus.memory_write_enable, 0);
    tick();
    drive_cpu(1'b0, 1'b0, 16'h0000, 16'h0000);
    @(negedge clock);
    chk("rd_cpu_rv", bus.cpu_read_valid, 1);
    chk("rd_cpu_data", bus.cpu_read_data, 16'hBEEF);
    chk("rd_aux_rv", bus.aux_read_valid, 0);
    chk("idle_mem_addr", bus.memory_address, 0);
    tick();

    // 4: cpu write 0x1234 -> 0x0020, aux idle
    drive_cpu(1'b1, 1'b1, 16'h0020, 16'h1234);
    @(negedge clock);
    chk("wr_cpu_grant", bus.cpu_grant, 1);
    chk("wr_mem_we", bus.memory_write_enable, 1);
    chk("wr_mem_addr", bus.memory_address, 16'h0020);
    chk("wr_mem_data", bus.memory_write_data, 16'h1234);
    tick();
    drive_cpu(1'b0, 1'b1, 16'h0020, 16'h1234);
    @(negedge clock);
    chk("wr_mem_we_after", bus.memory_write_enable, 0);
    chk("wr_cpu_rv_after", bus.cpu_read_valid, 0);
    chk("wr_aux_rv_after", bus.aux_read_valid, 0);
    tick();

    // re-reset so the cpu wins the first tie again
    reset = 1'b0;
    tick();
    reset = 1'b1;

    // 3: continuous contention, reads; expect CPUx4, AUXx4, ...
    cpu_n = 0;
    aux_n = 0;
    prev_cpu  = 1'b0;
    prev_addr = '0;
    for (int k = 0; k < 16; k++) begin
      exp_cpu = (((k / 4) % 2) == 0);
      drive_cpu(1'b1, 1'b0, 16'h0100 + 16'(cpu_n), 16'h0000);
      drive_aux(1'b1, 1'b0, 16'h0200 + 16'(aux_n), 16'h0000);
      cur_addr = exp_cpu ? (16'h0100 + 16'(cpu_n)) : (16'h0200 + 16'(aux_n));
      @(negedge clock);
      chk($sformatf("rr%0d_cpu_grant", k), bus.cpu_grant, exp_cpu);
      chk($sformatf("rr%0d_aux_grant", k), bus.aux_grant, !exp_cpu);
      chk($sformatf("rr%0d_mem_addr", k), bus.memory_address, cur_addr);
      if (k > 0) begin
        chk($sformatf("rr%0d_cpu_rv", k), bus.cpu_read_valid, prev_cpu);
        chk($sformatf("rr%0d_aux_rv", k), bus.aux_read_valid, !prev_cpu);
        chk($sformatf("rr%0d_rdata", k), bus.cpu_read_data, ram_word(prev_addr));
      end
      if (exp_cpu) cpu_n++; else aux_n++;
      prev_cpu  = exp_cpu;
      prev_addr = cur_addr;
      tick();
    end
    drive_cpu(1'b0, 1'b0, 16'h0000, 16'h0000);
    drive_aux(1'b0, 1'b0, 16'h0000, 16'h0000);
    @(negedge clock);
    chk("rr_tail_aux_rv", bus.aux_read_valid, 1);
    chk("rr_tail_cpu_rv", bus.cpu_read_valid, 0);
    chk("rr_tail_rdata", bus.aux_read_data, ram_word(prev_addr));
    tick();

    // 5: cpu owns for 2, drops; aux then gets a fresh 4-grant window
    // bit k = cycle k; cpu requests 1,1,0,1,1,1,1; aux always requests
    t5_cpu_req = 7'b1111011;
    t5_exp_cpu = 7'b1000011;
    for (int k = 0; k < 7; k++) begin
      drive_cpu(t5_cpu_req[k], 1'b0, 16'h0300, 16'h0000);
      drive_aux(1'b1, 1'b0, 16'h0400, 16'h0000);
      @(negedge clock);
      chk($sformatf("hold%0d_cpu_grant", k), bus.cpu_grant, t5_exp_cpu[k]);
      chk($sformatf("hold%0d_aux_grant", k), bus.aux_grant, !t5_exp_cpu[k]);
      tick();
    end
    drive_cpu(1'b0, 1'b0, 16'h0000, 16'h0000);
    drive_aux(1'b0, 1'b0, 16'h0000, 16'h0000);
    tick();

    // 6: reset right after an aux read grant drops the pending read
    drive_aux(1'b1, 1'b0, 16'h0500, 16'h0000);
    @(negedge clock);
    chk("mid_aux_grant", bus.aux_grant, 1);
    tick();
    reset = 1'b0;
    drive_aux(1'b0, 1'b0, 16'h0000, 16'h0000);
    @(negedge clock);
    chk("mid_aux_rv_in_rst", bus.aux_read_valid, 0);
    chk("mid_cpu_rv_in_rst", bus.cpu_read_valid, 0);
    tick();
    reset = 1'b1;
    drive_cpu(1'b1, 1'b0, 16'h0600, 16'h0000);
    drive_aux(1'b1, 1'b0, 16'h0700, 16'h0000);
    @(negedge clock);
    chk("post_rst_aux_rv", bus.aux_read_valid, 0);
    chk("post_rst_cpu_grant", bus.cpu_grant, 1);
    chk("post_rst_aux_grant", bus.aux_grant, 0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
